// File: rtl/mem_port_if.sv
// Handshake bundle between the two memory-port requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface mem_port_if #(
  parameter int CNT_W = 4
);
  logic             req_a;
  logic             req_b;
  logic             done_a;
  logic             done_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic             busy;
  logic             preempt;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output req_a, req_b, done_a, done_b,
    input  gnt_a, gnt_b, sel, busy, preempt, hold_cnt
  );

  modport slave (
    input  req_a, req_b, done_a, done_b,
    output gnt_a, gnt_b, sel, busy, preempt, hold_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared 16-bit RAM port with hold limit and turnaround.
// Define ARB_FIXED_PRIO_EN to make requester A always win and never be preempted.
module mem_port_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input logic       clk,
  input logic       rst_n,
  mem_port_if.slave bus
);

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, TURN} state_t;

  state_t           state_reg;
  logic             gnt_a_reg;
  logic             gnt_b_reg;
  logic             sel_reg;
  logic             preempt_reg;
  logic             last_reg;     // 0 = A owned last, 1 = B owned last
  logic [CNT_W-1:0] hold_cnt_reg;
  logic             hold_expired;

  assign hold_expired = (hold_cnt_reg == HOLD_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_a_reg    <= 1'b0;
      gnt_b_reg    <= 1'b0;
      sel_reg      <= 1'b0;
      preempt_reg  <= 1'b0;
      hold_cnt_reg <= '0;
      last_reg     <= 1'b1;
    end else begin
      preempt_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_a && (!bus.req_b || FIXED_PRIO || last_reg)) begin
            state_reg    <= OWN_A;
            gnt_a_reg    <= 1'b1;
            sel_reg      <= 1'b0;
            last_reg     <= 1'b0;
            hold_cnt_reg <= '0;
          end else if (bus.req_b) begin
            state_reg    <= OWN_B;
            gnt_b_reg    <= 1'b1;
            sel_reg      <= 1'b1;
            last_reg     <= 1'b1;
            hold_cnt_reg <= '0;
          end
        end

        OWN_A: begin
          // A normal done wins over a hold expiry in the same cycle.
          if (bus.done_a || !bus.req_a) begin
            gnt_a_reg    <= 1'b0;
            hold_cnt_reg <= '0;
            if (bus.req_b) begin
              state_reg <= TURN;
              sel_reg   <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else if (!FIXED_PRIO && hold_expired && bus.req_b) begin
            gnt_a_reg    <= 1'b0;
            hold_cnt_reg <= '0;
            state_reg    <= TURN;
            sel_reg      <= 1'b1;
            preempt_reg  <= 1'b1;
          end else if (!hold_expired) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end

        OWN_B: begin
          if (bus.done_b || !bus.req_b) begin
            gnt_b_reg    <= 1'b0;
            hold_cnt_reg <= '0;
            if (bus.req_a) begin
              state_reg <= TURN;
              sel_reg   <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end else if (hold_expired && bus.req_a) begin
            gnt_b_reg    <= 1'b0;
            hold_cnt_reg <= '0;
            state_reg    <= TURN;
            sel_reg      <= 1'b0;
            preempt_reg  <= 1'b1;
          end else if (!hold_expired) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end

        TURN: begin
          // sel already points at the incoming side; only it may be granted.
          hold_cnt_reg <= '0;
          if (sel_reg && bus.req_b) begin
            state_reg <= OWN_B;
            gnt_b_reg <= 1'b1;
            last_reg  <= 1'b1;
          end else if (!sel_reg && bus.req_a) begin
            state_reg <= OWN_A;
            gnt_a_reg <= 1'b1;
            last_reg  <= 1'b0;
          end else begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          gnt_a_reg <= 1'b0;
          gnt_b_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_a    = gnt_a_reg;
  assign bus.gnt_b    = gnt_b_reg;
  assign bus.sel      = sel_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.preempt  = preempt_reg;
  assign bus.hold_cnt = hold_cnt_reg;

endmodule
